// File: rtl/sw_bcd_sequencer.sv
// Serial binary-to-BCD converter (double dabble, one step per clock) with start/busy/done
// handshake and leading-zero mask. Optional macro AUTO_START_EN: start on any sw change.
module sw_bcd_sequencer #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IN_W-1:0]       sw,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [DIGITS-1:0] LZ_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [IN_W-1:0]      r_shreg;
    logic [4*DIGITS-1:0]  r_work;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf;
    logic                 r_busy;
    logic                 r_done;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [DIGITS-1:0]    r_lz_mask;
    logic                 r_overflow;

    logic                 w_go;
    logic                 w_capture;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_last_step;
    logic [4*DIGITS-1:0]  w_adj;
    logic [4*DIGITS-1:0]  w_work_nxt;
    logic                 w_shift_out;
    logic [DIGITS-1:0]    w_lz;

`ifdef AUTO_START_EN
    logic [IN_W-1:0]      r_last_op;

    always_comb w_go = start | (sw != r_last_op);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_op <= '0;
        end else if (w_capture) begin
            r_last_op <= sw;
        end
    end
`else
    always_comb w_go = start;
`endif

    assign w_last_step = (r_cnt == CNT_W'(IN_W - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_step = 1'b1;
                if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Add-3 correction on every digit, then shift the next operand bit into digit 0.
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
        w_shift_out = w_adj[4*DIGITS-1];
        w_work_nxt  = {w_adj[4*DIGITS-2:0], r_shreg[IN_W-1]};
    end

    // A digit is blanked only when it and every more significant digit are zero.
    always_comb begin
        logic v_run;
        v_run = 1'b1;
        w_lz  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_run   = v_run & (r_work[4*i +: 4] == 4'd0);
            w_lz[i] = v_run;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg    <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_lz_mask  <= LZ_RESET;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_shreg <= sw;
                r_work  <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
                r_busy  <= 1'b1;
            end
            if (w_step) begin
                r_shreg <= {r_shreg[IN_W-2:0], 1'b0};
                r_work  <= w_work_nxt;
                r_cnt   <= r_cnt + CNT_W'(1);
                r_ovf   <= r_ovf | w_shift_out;
            end
            if (w_finish) begin
                r_bcd      <= r_work;
                r_overflow <= r_ovf;
                r_lz_mask  <= w_lz;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign lz_mask  = r_lz_mask;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_sw_bcd_sequencer.sv
// Scoreboard bench for sw_bcd_sequencer: a decimal-arithmetic model predicts each result
// and its done cycle; a monitor checks busy/done every cycle and results on done.
module tb_sw_bcd_sequencer;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  lz;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  sw = '0;
    logic        start = 1'b0;
    logic        busy, done, overflow;
    logic [15:0] bcd;
    logic [3:0]  lz_mask;

    logic [9:0]  sw2 = '0;
    logic        start2 = 1'b0;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;
    logic [1:0]  lz_mask2;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_free_at = 0;
    int   m_acc = -100;
    logic [9:0] m_last_op = '0;
    exp_t q[$];

    sw_bcd_sequencer #(.IN_W(10), .DIGITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .sw(sw), .start(start), .busy(busy),
        .done(done), .bcd(bcd), .lz_mask(lz_mask), .overflow(overflow)
    );

    sw_bcd_sequencer #(.IN_W(10), .DIGITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .sw(sw2), .start(start2), .busy(busy2),
        .done(done2), .bcd(bcd2), .lz_mask(lz_mask2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Reference result from decimal arithmetic on the operand value.
    function automatic exp_t model(input int v, input int nd);
        exp_t e;
        e.bcd = '0;
        e.lz = '0;
        e.done_cyc = 0;
        for (int i = 0; i < nd; i++) e.bcd[4*i +: 4] = 4'((v / pow10(i)) % 10);
        e.ovf = (v >= pow10(nd));
        for (int i = 1; i < nd; i++) e.lz[i] = (((v % pow10(nd)) / pow10(i)) == 0);
        return e;
    endfunction

    // Acceptance model: a request is taken once the previous conversion has finished.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset_n) begin
            logic go;
            exp_t e;
            go = start;
`ifdef AUTO_START_EN
            go = go | (sw != m_last_op);
`endif
            if (go && cyc >= m_free_at) begin
                e = model(int'(sw), 4);
                e.done_cyc = cyc + 11;
                q.push_back(e);
                m_acc = cyc;
                m_free_at = cyc + 12;
                m_last_op = sw;
            end
        end
    end

    // Monitor: busy window and done pulse every cycle, result fields on each done.
    initial forever begin
        logic exp_busy, exp_done;
        exp_t e;
        @(negedge clk);
        exp_busy = (m_acc >= 0) && (cyc >= m_acc) && (cyc <= m_acc + 10);
        exp_done = (q.size() > 0) && (q[0].done_cyc <= cyc);
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
            e = q.pop_front();
            if (done) begin
                check("bcd", 32'(bcd), 32'(e.bcd));
                check("lz_mask", 32'(lz_mask), 32'(e.lz));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [9:0] v);
        sw = v;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        m_free_at = 0;
        m_acc = -100;
        m_last_op = '0;
        #1;
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_lz", 32'(lz_mask), 32'b1110);
        check("rst_lz2", 32'(lz_mask2), 32'b10);
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic conv2(input int v);
        exp_t e;
        int   k;
        e = model(v, 2);
        sw2 = 10'(v);
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 20) begin
            step(1);
            k++;
        end
        check("d2_done_seen", 32'(done2), 32'h1);
        check("d2_bcd", 32'(bcd2), 32'(e.bcd[7:0]));
        check("d2_lz", 32'(lz_mask2), 32'(e.lz[1:0]));
        check("d2_ovf", 32'(overflow2), 32'(e.ovf));
        step(2);
    endtask

    initial begin
        step(1);
        do_reset();
        step(2);

        pulse(10'b0000011001);
        step(14);

        pulse(10'b0001011001);
        step(14);
        sw = 10'h3FF;
        start = 1'b1;
        step(13);
        start = 1'b0;
        step(14);

        pulse(10'b0000001110);
        step(2);
        pulse(10'b0001010100);
        step(14);

        pulse(10'd777);
        step(4);
        do_reset();
        step(1);
        pulse(10'b0001010100);
        step(14);

`ifdef AUTO_START_EN
        sw = 10'd0;
        do_reset();
        step(3);
        sw = 10'd14;
        step(16);
`endif

        for (int i = 0; i < 40; i++) begin
            sw = 10'($urandom_range(0, 1023));
            start = 1'b1;
            step($urandom_range(1, 3));
            start = 1'b0;
            step($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) sw = 10'($urandom_range(0, 1023));
            step($urandom_range(0, 10));
        end
        start = 1'b0;
        step(16);
        check("queue_drained", 32'(q.size()), 32'h0);

        conv2(150);
        conv2(99);
        conv2(5);
        conv2(1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
